// File: rtl/sme_host_pkg.sv
// Shared types and defaults for the string-match engine host.
package sme_host_pkg;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam int TMO_DEF     = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_STR = 2'd1,
    ST_SEND_PAT = 2'd2,
    ST_WAIT     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_TMO   = 2'd1,
    ERR_EMPTY = 2'd2,
    ERR_OVF   = 2'd3
  } err_e;

endpackage

// File: rtl/sme_host_buf.sv
// Byte-wide load buffer: appends at the current length, flags sticky
// overflow on writes past DEPTH, and can restart from slot 0.
module sme_host_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          wr_restart,
  input  logic          clr_len,
  input  logic          clr_ovf,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] len,
  output logic          ovf
);

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  // Next length/overflow and write decode; a job-end clear beats a write.
  always_comb begin
    len_d     = len_q;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    if (clr_len || clr_ovf) begin
      if (clr_len) len_d = '0;
      else         len_d = len_q;
      if (clr_ovf) ovf_d = 1'b0;
      else         ovf_d = ovf_q;
    end else if (wr_en) begin
      if (wr_restart) begin
        mem_we    = 1'b1;
        mem_waddr = '0;
        len_d     = LW'(1);
      end else if (len_q == LW'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = len_q[AW-1:0];
        len_d     = len_q + LW'(1);
      end
    end else begin
      len_d = len_q;
    end
  end

  // Length and sticky overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  // Byte storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];
  assign len     = len_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/sme_host.sv
// Host sequencer for a string-match engine: streams the loaded string and
// pattern, then waits (with timeout) for the engine's result.
module sme_host
  import sme_host_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int TMO     = TMO_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       reuse_str,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       eng_valid,
  input  logic       eng_match,
  input  logic [4:0] eng_index,
  output logic       busy,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [1:0] err
);

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       restart_q, restart_d;
  logic [7:0] chardata_q, chardata_d;
  logic       isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic       busy_q, busy_d, res_valid_q, res_valid_d, res_match_q, res_match_d;
  logic [4:0] res_index_q, res_index_d;
  logic [1:0] err_q, err_d;

  logic       wr_ok, job_end;
  logic [7:0] str_rd, pat_rd;
  logic [5:0] slen;
  logic [3:0] plen;
  logic       str_ovf, pat_ovf;
  logic [4:0] str_raddr;
  logic [2:0] pat_raddr;

  assign wr_ok     = wr_en & ~busy_q;
  // Read slot 0 ahead of each phase so the first byte is ready on entry.
  assign str_raddr = (state_q == ST_SEND_STR) ? idx_q[4:0] : 5'd0;
  assign pat_raddr = (state_q == ST_SEND_PAT) ? idx_q[2:0] : 3'd0;

  sme_host_buf #(.DEPTH(STR_MAX)) u_str (
    .clk(clk), .reset(reset), .wr_en(wr_ok & ~wr_sel), .wr_data(wr_data),
    .wr_restart(restart_q), .clr_len(1'b0), .clr_ovf(job_end),
    .rd_addr(str_raddr), .rd_data(str_rd), .len(slen), .ovf(str_ovf)
  );

  sme_host_buf #(.DEPTH(PAT_MAX)) u_pat (
    .clk(clk), .reset(reset), .wr_en(wr_ok & wr_sel), .wr_data(wr_data),
    .wr_restart(1'b0), .clr_len(job_end), .clr_ovf(job_end),
    .rd_addr(pat_raddr), .rd_data(pat_rd), .len(plen), .ovf(pat_ovf)
  );

  // Next-state and next-output logic; outputs describe the coming cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    chardata_d  = 8'd0;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    err_d       = err_q;
    job_end     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (str_ovf || pat_ovf) begin
          res_valid_d = 1'b1;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          err_d       = ERR_OVF;
          job_end     = 1'b1;
        end else if (plen == 4'd0 || (slen == 6'd0 && !reuse_str)) begin
          res_valid_d = 1'b1;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          err_d       = ERR_EMPTY;
          job_end     = 1'b1;
        end else if (!reuse_str) begin
          state_d    = ST_SEND_STR;
          chardata_d = str_rd;
          isstring_d = 1'b1;
          idx_d      = 6'd1;
          busy_d     = 1'b1;
        end else begin
          state_d     = ST_SEND_PAT;
          chardata_d  = pat_rd;
          ispattern_d = 1'b1;
          idx_d       = 6'd1;
          busy_d      = 1'b1;
        end
      end
      ST_SEND_STR: begin
        if (idx_q < slen) begin
          chardata_d = str_rd;
          isstring_d = 1'b1;
          idx_d      = idx_q + 6'd1;
        end else begin
          state_d     = ST_SEND_PAT;
          chardata_d  = pat_rd;
          ispattern_d = 1'b1;
          idx_d       = 6'd1;
        end
      end
      ST_SEND_PAT: begin
        if (idx_q < {2'b00, plen}) begin
          chardata_d  = pat_rd;
          ispattern_d = 1'b1;
          idx_d       = idx_q + 6'd1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (eng_valid) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          res_valid_d = 1'b1;
          res_match_d = eng_match;
          res_index_d = eng_index;
          err_d       = ERR_OK;
          job_end     = 1'b1;
        end else if (cnt_q == 8'(TMO)) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          res_valid_d = 1'b1;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          err_d       = ERR_TMO;
          job_end     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Restart flag: armed at job end, consumed by the next string write.
  always_comb begin
    if (job_end)                restart_d = 1'b1;
    else if (wr_ok && !wr_sel)  restart_d = 1'b0;
    else                        restart_d = restart_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 6'd0;
      cnt_q       <= 8'd0;
      restart_q   <= 1'b0;
      chardata_q  <= 8'd0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= 5'd0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      restart_q   <= restart_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      err_q       <= err_d;
    end
  end

  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign err       = err_q;

endmodule

// File: doc/sme_host.md
SME_HOST -- requirements
Module: sme_host

Interface
REQ-001 STR_MAX, 32, string buffer depth in bytes (max string length).
REQ-002 PAT_MAX, 8, pattern buffer depth in bytes (max pattern length).
REQ-003 TMO, 255, WAIT-state cycle limit before timeout.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 wr_en  in  1  load-port write strobe.
REQ-007 wr_sel  in  1  target buffer: 0 = string, 1 = pattern.
REQ-008 wr_data  in  8  byte to load.
REQ-009 start  in  1  one-cycle job start pulse.
REQ-010 reuse_str  in  1  sampled with start; 1 = do not resend the string.
REQ-011 chardata  out  8  byte to engine.
REQ-012 isstring  out  1  chardata is a string byte.
REQ-013 ispattern  out  1  chardata is a pattern byte.
REQ-014 eng_valid  in  1  engine result valid.
REQ-015 eng_match  in  1  engine match flag.
REQ-016 eng_index  in  5  engine match index.
REQ-017 busy  out  1  job in progress.
REQ-018 res_valid  out  1  one-cycle result pulse.
REQ-019 res_match, res_index  out  1, 5  captured result; held until the next res_valid.
REQ-020 err  out  2  result status: 0 ok, 1 timeout, 2 empty buffer, 3 load overflow.

Function
REQ-021 FSM: IDLE -> SEND_STR -> SEND_PAT -> WAIT -> IDLE; SEND_STR skipped when reuse_str=1.
REQ-022 All engine-side outputs are registered: start at cycle t gives first byte at t+1.
REQ-023 SEND_STR drives str[0..slen-1] one per cycle with isstring=1, then SEND_PAT follows the next cycle with no gap.
REQ-024 SEND_PAT drives pat[0..plen-1] one per cycle with ispattern=1; the cycle after the last byte, chardata=0 and isstring=ispattern=0 (WAIT).
REQ-025 isstring and ispattern are never both 1.
REQ-026 In WAIT, eng_valid=1 captures eng_match/eng_index; the next cycle gives res_valid=1, err=0, busy=0, state IDLE.
REQ-027 The WAIT counter (8-bit) increments each WAIT cycle; at TMO, FSM -> IDLE, res_valid=1, res_match=0, res_index=0, err=1.
REQ-028 eng_valid outside WAIT is ignored.
REQ-029 Load writes are accepted only when busy=0; writes while busy are dropped silently.
REQ-030 A string write beyond STR_MAX, or a pattern write beyond PAT_MAX, is dropped and sets sticky ovf; the next start reports err=3 via res_valid, with no transmission.
REQ-031 Start with plen=0, or with slen=0 and reuse_str=0, produces res_valid with err=2 the next cycle and no transmission.
REQ-032 A start while busy is ignored.
REQ-033 Error priority: ovf over empty.
REQ-034 At job end, plen clears and ovf clears.
REQ-035 The string buffer is retained after a job; the first string write after a completed job restarts slen at 1.
REQ-036 slen is 6-bit; plen is 4-bit.
REQ-037 busy=1 from the cycle after an accepted start until the res_valid cycle, exclusive.

Reset
REQ-038 Reset clears the FSM to IDLE and clears all outputs: chardata=0, isstring=0, ispattern=0, busy=0, res_valid=0, res_match=0, res_index=0, err=0.
REQ-039 Reset also clears slen, plen, ovf, the timeout counter and the restart flag; buffer contents need no reset.
REQ-040 Reset mid-job aborts the job immediately, with no res_valid.

Structure
REQ-041 The shared package holds the FSM state enum, the err codes, and the STR_MAX/PAT_MAX/TMO defaults.
REQ-042 One sub-module, sme_host_buf: a byte-wide register file with write pointer, length and overflow, instantiated twice (string, pattern).

Verification
REQ-043 Load "ab cd" and pattern "cd", then start; engine model returns match=1, index=3 -> isstring 5 cycles, ispattern 2 cycles, then res_valid, res_match=1, res_index=3, err=0.
REQ-044 Second job with reuse_str=1 and pattern "x" -> no isstring cycles, ispattern 1 cycle, result captured.
REQ-045 Engine never asserts valid -> res_valid exactly 256 cycles after WAIT entry, err=1, res_match=0.
REQ-046 Write 9 pattern bytes, then start -> err=3 next cycle, no engine traffic.
REQ-047 Start with plen=0 -> err=2; a start while busy has no effect.
REQ-048 Assert reset during SEND_PAT -> all outputs 0 next edge; a subsequent job runs normally.
